// File: rtl/output_port_vc_arbiter_pkg.sv
// Router-wide types and constants shared by the allocation stages.
// Flit-type view, default sizes and the index-width helper.
package output_port_vc_arbiter_pkg;

  localparam int DEF_INPUT_NUM = 5;
  localparam int DEF_VC_NUM    = 4;

  // {head, tail}
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/one_hot_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps.
// Returns a one-hot grant, its index and a valid flag.
module one_hot_rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/output_port_vc_arbiter.sv
// Switch allocation for one output port with per-VC wormhole locks.
// Define OUTPUT_PORT_VC_ARBITER_ASSERT_EN for simulation assertions.
module output_port_vc_arbiter
  import output_port_vc_arbiter_pkg::*;
#(
  parameter int INPUT_NUM          = DEF_INPUT_NUM,
  parameter int INPUT_IDX_W        = idx_w(INPUT_NUM),
  parameter int VC_NUM             = DEF_VC_NUM,
  parameter int VC_NUM_IDX_W       = idx_w(VC_NUM),
  parameter int VC_DEPTH           = 1,
  parameter int VC_DEPTH_COUNTER_W = $clog2(VC_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [INPUT_NUM-1:0]                 req_vld_i,
  input  logic [INPUT_NUM*VC_NUM_IDX_W-1:0]    req_vc_id_i,
  input  logic [INPUT_NUM-1:0]                 req_head_i,
  input  logic [INPUT_NUM-1:0]                 req_tail_i,
  input  logic [VC_NUM*VC_DEPTH_COUNTER_W-1:0] vc_credit_counter_i,
  output logic [INPUT_NUM-1:0]                 gnt_o,
  output logic                                 consume_vc_credit_vld_o,
  output logic [VC_NUM_IDX_W-1:0]              consume_vc_credit_vc_id_o,
  output logic [VC_NUM-1:0]                    vc_lock_o,
  output logic [VC_NUM*INPUT_IDX_W-1:0]        vc_owner_o
);

  localparam int VW = VC_NUM_IDX_W;
  localparam int CW = VC_DEPTH_COUNTER_W;
  localparam int IW = INPUT_IDX_W;

  logic [IW-1:0]     rr_ptr;
  logic [VC_NUM-1:0] vc_lock;
  logic [IW-1:0]     vc_owner [VC_NUM];

  logic [INPUT_NUM-1:0] elig;
  logic [INPUT_NUM-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_vld;
  logic [VW-1:0]        vid;
  logic [VW-1:0]        gnt_vc;
  flit_type_e           gnt_type;

  always_comb begin
    elig = '0;
    vid  = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      vid = req_vc_id_i[i*VW +: VW];
      if (req_vld_i[i] && int'(vid) < VC_NUM) begin
        if (vc_credit_counter_i[int'(vid)*CW +: CW] != '0) begin
          if (vc_lock[vid])
            elig[i] = (vc_owner[vid] == IW'(i)) && !req_head_i[i];
          else
            elig[i] = req_head_i[i];
        end
      end
    end
  end

  one_hot_rr_arbiter #(
    .N  (INPUT_NUM),
    .IW (IW)
  ) u_rr (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gnt_vc   = '0;
    gnt_type = FLIT_BODY;
    if (gnt_vld) begin
      gnt_vc   = req_vc_id_i[int'(gnt_idx)*VW +: VW];
      gnt_type = flit_type_e'({req_head_i[gnt_idx], req_tail_i[gnt_idx]});
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr  <= '0;
      vc_lock <= '0;
      for (int v = 0; v < VC_NUM; v++)
        vc_owner[v] <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == IW'(INPUT_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      // Tail always releases, so a single-flit packet never locks.
      case (gnt_type)
        FLIT_HEAD: begin
          vc_lock[gnt_vc]  <= 1'b1;
          vc_owner[gnt_vc] <= gnt_idx;
        end
        FLIT_TAIL, FLIT_SINGLE: vc_lock[gnt_vc] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign gnt_o                     = gnt;
  assign consume_vc_credit_vld_o   = gnt_vld;
  assign consume_vc_credit_vc_id_o = gnt_vc;
  assign vc_lock_o                 = vc_lock;

  always_comb begin
    vc_owner_o = '0;
    for (int v = 0; v < VC_NUM; v++)
      vc_owner_o[v*IW +: IW] = vc_owner[v];
  end

`ifdef OUTPUT_PORT_VC_ARBITER_ASSERT_EN
  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (req_vld_i[i]) begin
          assert (int'(req_vc_id_i[i*VW +: VW]) < VC_NUM)
            else $error("vc id out of range on input %0d", i);
          if (int'(req_vc_id_i[i*VW +: VW]) < VC_NUM)
            assert (!(req_head_i[i] && vc_lock[req_vc_id_i[i*VW +: VW]]
                      && vc_owner[req_vc_id_i[i*VW +: VW]] == IW'(i)))
              else $error("owner head on locked vc, input %0d", i);
        end
      end
      assert ($onehot0(gnt_o)) else $error("grant not one-hot");
      if (gnt_vld && int'(gnt_vc) < VC_NUM)
        assert (vc_credit_counter_i[int'(gnt_vc)*CW +: CW] != '0)
          else $error("grant on vc %0d with no credit", gnt_vc);
    end
  end
`endif

endmodule

// File: tb/tb_output_port_vc_arbiter.sv
// Directed bench for output_port_vc_arbiter (default build).
// Inputs change on negedge; outputs compared 1ns later.
module tb_output_port_vc_arbiter;

  localparam int IN = 5;
  localparam int VC = 4;
  localparam int VW = 2;
  localparam int IW = 3;
  localparam int CW = 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [IN-1:0]      req_vld = '0;
  logic [IN*VW-1:0]   req_vc = '0;
  logic [IN-1:0]      req_head = '0;
  logic [IN-1:0]      req_tail = '0;
  logic [VC*CW-1:0]   credit = '1;
  logic [IN-1:0]      gnt;
  logic               c_vld;
  logic [VW-1:0]      c_vc;
  logic [VC-1:0]      lock;
  logic [VC*IW-1:0]   owner;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  output_port_vc_arbiter dut (
    .clk                       (clk),
    .rstn                      (rstn),
    .req_vld_i                 (req_vld),
    .req_vc_id_i               (req_vc),
    .req_head_i                (req_head),
    .req_tail_i                (req_tail),
    .vc_credit_counter_i       (credit),
    .gnt_o                     (gnt),
    .consume_vc_credit_vld_o   (c_vld),
    .consume_vc_credit_vc_id_o (c_vc),
    .vc_lock_o                 (lock),
    .vc_owner_o                (owner)
  );

  task automatic set_req(input int i, input int vc,
                         input bit h, input bit t);
    req_vld[i]         = 1'b1;
    req_vc[i*VW +: VW] = VW'(vc);
    req_head[i]        = h;
    req_tail[i]        = t;
  endtask

  task automatic clr_reqs();
    req_vld  = '0;
    req_vc   = '0;
    req_head = '0;
    req_tail = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clr_reqs();
    credit = '1;
    #12;
    tests++;
    if (gnt !== '0 || c_vld !== 1'b0 || c_vc !== '0) begin
      errs++;
      $display("FAIL reset_gnt got gnt=%b vld=%b vc=%0d want 0/0/0",
               gnt, c_vld, c_vc);
    end
    tests++;
    if (lock !== '0 || owner !== '0) begin
      errs++;
      $display("FAIL reset_lock got lock=%b owner=%h want 0/0",
               lock, owner);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (gnt !== '0 || c_vld !== 1'b0 || lock !== '0) begin
      errs++;
      $display("FAIL idle got gnt=%b vld=%b lock=%b want 0/0/0",
               gnt, c_vld, lock);
    end
  endtask

  task automatic test_round_robin();
    logic [IN-1:0] exp_g [4];
    logic [VW-1:0] exp_v [4];
    exp_g = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
    exp_v = '{2'd0, 2'd1, 2'd2, 2'd0};
    @(negedge clk);
    clr_reqs();
    set_req(0, 0, 1, 1);
    set_req(2, 1, 1, 1);
    set_req(4, 2, 1, 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (gnt !== exp_g[c] || c_vld !== 1'b1 || c_vc !== exp_v[c]) begin
        errs++;
        $display("FAIL rr_cyc%0d got gnt=%b vld=%b vc=%0d want %b/1/%0d",
                 c, gnt, c_vld, c_vc, exp_g[c], exp_v[c]);
      end
      @(negedge clk);
    end
    clr_reqs();
  endtask

  // rr_ptr is 1 on entry
  task automatic test_wormhole();
    @(negedge clk);
    set_req(1, 2, 1, 0);
    set_req(3, 2, 1, 1);
    #1;
    tests++;
    if (gnt !== 5'b00010 || lock[2] !== 1'b0) begin
      errs++;
      $display("FAIL wh_head got gnt=%b lock=%b want 00010/0",
               gnt, lock);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_req(1, 2, 0, c == 2);
      #1;
      tests++;
      if (gnt !== 5'b00010 || lock[2] !== 1'b1 ||
          owner[2*IW +: IW] !== 3'd1 || c_vc !== 2'd2) begin
        errs++;
        $display("FAIL wh_body%0d got gnt=%b lock=%b own=%0d vc=%0d want 00010/1/1/2",
                 c, gnt, lock[2], owner[2*IW +: IW], c_vc);
      end
    end
    @(negedge clk);
    req_vld[1] = 1'b0;
    #1;
    tests++;
    if (gnt !== 5'b01000 || lock[2] !== 1'b0 || c_vc !== 2'd2) begin
      errs++;
      $display("FAIL wh_next got gnt=%b lock=%b vc=%0d want 01000/0/2",
               gnt, lock[2], c_vc);
    end
    @(negedge clk);
    clr_reqs();
    #1;
    tests++;
    if (gnt !== '0 || c_vld !== 1'b0 || lock !== '0) begin
      errs++;
      $display("FAIL wh_idle got gnt=%b vld=%b lock=%b want 0/0/0",
               gnt, c_vld, lock);
    end
  endtask

  // rr_ptr is 4 on entry
  task automatic test_credit_stall();
    @(negedge clk);
    credit = 4'b1101;
    set_req(0, 1, 1, 1);
    set_req(1, 3, 1, 1);
    #1;
    tests++;
    if (gnt !== 5'b00010 || c_vc !== 2'd3 || c_vld !== 1'b1) begin
      errs++;
      $display("FAIL cr_stall got gnt=%b vc=%0d vld=%b want 00010/3/1",
               gnt, c_vc, c_vld);
    end
    @(negedge clk);
    req_vld[1] = 1'b0;
    #1;
    tests++;
    if (gnt !== '0 || c_vld !== 1'b0) begin
      errs++;
      $display("FAIL cr_zero got gnt=%b vld=%b want 0/0", gnt, c_vld);
    end
    @(negedge clk);
    credit = 4'b1111;
    #1;
    tests++;
    if (gnt !== 5'b00001 || c_vc !== 2'd1) begin
      errs++;
      $display("FAIL cr_return got gnt=%b vc=%0d want 00001/1",
               gnt, c_vc);
    end
    @(negedge clk);
    clr_reqs();
    set_req(2, 0, 0, 0);
    #1;
    tests++;
    if (gnt !== '0 || c_vld !== 1'b0) begin
      errs++;
      $display("FAIL body_unlocked got gnt=%b vld=%b want 0/0",
               gnt, c_vld);
    end
    @(negedge clk);
    clr_reqs();
  endtask

  // rr_ptr is 1 on entry
  task automatic test_reset_mid_packet();
    @(negedge clk);
    set_req(2, 0, 1, 0);
    #1;
    tests++;
    if (gnt !== 5'b00100) begin
      errs++;
      $display("FAIL rm_head got gnt=%b want 00100", gnt);
    end
    @(negedge clk);
    clr_reqs();
    #1;
    tests++;
    if (lock !== 4'b0001 || owner[0 +: IW] !== 3'd2) begin
      errs++;
      $display("FAIL rm_locked got lock=%b own=%0d want 0001/2",
               lock, owner[0 +: IW]);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (lock !== '0 || owner !== '0) begin
      errs++;
      $display("FAIL rm_async got lock=%b owner=%h want 0/0",
               lock, owner);
    end
    @(negedge clk);
    rstn = 1'b1;
    set_req(2, 0, 0, 0);
    #1;
    tests++;
    if (gnt !== '0 || c_vld !== 1'b0) begin
      errs++;
      $display("FAIL rm_body got gnt=%b vld=%b want 0/0", gnt, c_vld);
    end
    @(negedge clk);
    clr_reqs();
    set_req(1, 1, 1, 1);
    set_req(4, 3, 1, 1);
    #1;
    tests++;
    if (gnt !== 5'b00010 || c_vc !== 2'd1) begin
      errs++;
      $display("FAIL rm_ptr got gnt=%b vc=%0d want 00010/1", gnt, c_vc);
    end
    @(negedge clk);
    clr_reqs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
